// File: rtl/packet_buffer_ctrl_pkg.sv
// Shared types and width helpers for the packet buffer controller.
package pkt_buffer_pkg;

    // Read-side sequencer states.
    typedef enum logic [0:0] {
        OUT_IDLE,
        OUT_STREAM
    } out_state_t;

    // RAM address width for a buffer of the given depth.
    function automatic int addr_width(input int size);
        return $clog2(size);
    endfunction

    // Pointer width: one extra bit so full and empty are distinguishable.
    function automatic int ptr_width(input int size);
        return $clog2(size) + 1;
    endfunction

    // Occupancy counter width able to represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/packet_buffer_ctrl_len_fifo.sv
// Register FIFO holding the lengths of committed, not-yet-drained packets.
module pkt_len_fifo
    import pkt_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              data_i,
    input  logic                          pop_i,
    output logic [WIDTH-1:0]              data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [count_width(DEPTH)-1:0] count_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [IW-1:0]    wr_idx_q, wr_idx_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_idx_q];

    // Next-state: guarded push/pop, indices wrap naturally (DEPTH is a power of two).
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        if (do_push) begin
            mem_d[wr_idx_q] = data_i;
            wr_idx_d        = wr_idx_q + IW'(1);
        end
        if (do_pop) begin
            rd_idx_d = rd_idx_q + IW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/packet_buffer_ctrl.sv
// Packet store-and-forward controller over an external dual-port RAM.
// Port A writes incoming words; port B reads committed packets in order.
// The ram_a_*/ram_b_* ports map one-to-one onto the MEM modport of
// interface_memory on dual_port_ram at the integration level.
module packet_buffer_ctrl
    import pkt_buffer_pkg::*;
#(
    parameter int  MEMORY_BUS_WIDTH = 32,
    parameter int  SIZE             = 1024,
    parameter int  PKT_DEPTH        = 8,
    localparam int ADDR_W           = addr_width(SIZE),
    localparam int PTR_W            = ptr_width(SIZE),
    localparam int CNT_W            = count_width(PKT_DEPTH)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MEMORY_BUS_WIDTH-1:0] in_data,
    input  logic                        in_last,
    input  logic                        in_abort,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MEMORY_BUS_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic                        ram_a_enable,
    output logic                        ram_a_wb,
    output logic [ADDR_W-1:0]           ram_a_addr,
    output logic [MEMORY_BUS_WIDTH-1:0] ram_a_data,
    output logic                        ram_b_enable,
    output logic                        ram_b_wb,
    output logic [ADDR_W-1:0]           ram_b_addr,
    input  logic [MEMORY_BUS_WIDTH-1:0] ram_b_rdata,
    output logic [CNT_W-1:0]            pkt_count,
    output logic                        err_overflow,
    output logic                        drop_pulse
);

    // Pointers carry one wrap bit: wr_ptr - rd_ptr ranges 0..SIZE.
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] cur_len_q, cur_len_d;
    logic [PTR_W-1:0] remaining_q, remaining_d;
    logic             drop_pulse_q, drop_pulse_d;
    logic             err_overflow_q, err_overflow_d;
    out_state_t       state_q, state_d;

    logic [PTR_W-1:0] used;
    logic             accept;
    logic             ovf_drop;
    logic             rd_fire;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PTR_W-1:0] fifo_push_len;
    logic [PTR_W-1:0] fifo_head;

    pkt_len_fifo #(
        .DEPTH (PKT_DEPTH),
        .WIDTH (PTR_W)
    ) u_len_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .data_i  (fifo_push_len),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (pkt_count)
    );

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------

    assign used = wr_ptr_q - rd_ptr_q;

    // Ready and overflow detection depend only on registered state.
    always_comb begin
        in_ready = !reset && (used < PTR_W'(SIZE)) && !fifo_full;
        accept   = in_valid && in_ready && !in_abort;
        // Open packet occupies the whole RAM with nothing committed to drain:
        // it can never complete, so it is discarded.
        ovf_drop = (used == PTR_W'(SIZE)) && (commit_ptr_q == rd_ptr_q) && !in_abort;
    end

    // Write-pointer, open-packet length and commit bookkeeping.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        commit_ptr_d   = commit_ptr_q;
        cur_len_d      = cur_len_q;
        fifo_push      = 1'b0;
        fifo_push_len  = cur_len_q + PTR_W'(1);
        drop_pulse_d   = in_abort;
        err_overflow_d = ovf_drop;
        if (in_abort || ovf_drop) begin
            // Rewind over the open packet; abort wins over a concurrent last.
            wr_ptr_d  = commit_ptr_q;
            cur_len_d = '0;
        end else if (accept) begin
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            cur_len_d = cur_len_q + PTR_W'(1);
            if (in_last) begin
                commit_ptr_d = wr_ptr_q + PTR_W'(1);
                fifo_push    = 1'b1;
                cur_len_d    = '0;
            end
        end
    end

    // Port A drives straight from the accept handshake.
    always_comb begin
        ram_a_enable = accept;
        ram_a_wb     = accept;
        ram_a_addr   = wr_ptr_q[ADDR_W-1:0];
        ram_a_data   = in_data;
    end

    // Write-side registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            commit_ptr_q   <= '0;
            cur_len_q      <= '0;
            drop_pulse_q   <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            commit_ptr_q   <= commit_ptr_d;
            cur_len_q      <= cur_len_d;
            drop_pulse_q   <= drop_pulse_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign drop_pulse   = drop_pulse_q;
    assign err_overflow = err_overflow_q;

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= OUT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: idle cycle between packets is intentional.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_IDLE: begin
                if (!fifo_empty) begin
                    state_d = OUT_STREAM;
                end
            end
            OUT_STREAM: begin
                if (rd_fire && out_last) begin
                    state_d = OUT_IDLE;
                end
            end
            default: state_d = OUT_IDLE;
        endcase
    end

    // FSM outputs; port B reads combinationally so data follows rd_ptr.
    always_comb begin
        out_valid    = (state_q == OUT_STREAM);
        ram_b_enable = (state_q == OUT_STREAM);
        ram_b_wb     = 1'b0;
        ram_b_addr   = rd_ptr_q[ADDR_W-1:0];
        out_data     = ram_b_rdata;
        out_last     = out_valid && (remaining_q == PTR_W'(1));
        rd_fire      = out_valid && out_ready;
    end

    // Read pointer and per-packet countdown.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        fifo_pop    = 1'b0;
        if (state_q == OUT_IDLE) begin
            if (!fifo_empty) begin
                remaining_d = fifo_head;
            end
        end else if (rd_fire) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            remaining_d = remaining_q - PTR_W'(1);
            fifo_pop    = out_last;
        end
    end

    // Read-side datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            remaining_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_packet_buffer_ctrl.sv
// Bench for packet_buffer_ctrl: vector table, directed corner sequences and
// randomized traffic against a queue-based packet model.
module tb_packet_buffer_ctrl;

    localparam int W         = 32;
    localparam int SIZE      = 4;
    localparam int PKT_DEPTH = 2;
    localparam int AW        = 2;
    localparam int CW        = 2;

    logic          clock = 1'b0;
    logic          reset, in_valid, in_last, in_abort, out_ready;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid, out_last;
    logic [W-1:0]  out_data;
    logic          ram_a_enable, ram_a_wb, ram_b_enable, ram_b_wb;
    logic [AW-1:0] ram_a_addr, ram_b_addr;
    logic [W-1:0]  ram_a_data, ram_b_rdata;
    logic [CW-1:0] pkt_count;
    logic          err_overflow, drop_pulse;

    packet_buffer_ctrl #(
        .MEMORY_BUS_WIDTH (W),
        .SIZE             (SIZE),
        .PKT_DEPTH        (PKT_DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_abort     (in_abort),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .ram_a_enable (ram_a_enable),
        .ram_a_wb     (ram_a_wb),
        .ram_a_addr   (ram_a_addr),
        .ram_a_data   (ram_a_data),
        .ram_b_enable (ram_b_enable),
        .ram_b_wb     (ram_b_wb),
        .ram_b_addr   (ram_b_addr),
        .ram_b_rdata  (ram_b_rdata),
        .pkt_count    (pkt_count),
        .err_overflow (err_overflow),
        .drop_pulse   (drop_pulse)
    );

    always #5 clock = ~clock;

    // Dual-port RAM: synchronous write on A, combinational read on B.
    logic [W-1:0] ram [SIZE];
    always @(posedge clock) begin
        if (ram_a_enable && ram_a_wb) ram[ram_a_addr] <= ram_a_data;
    end
    assign ram_b_rdata = ram[ram_b_addr];

    int total = 0;
    int bad   = 0;

    // Packet-level reference model.
    logic [W-1:0] cw[$];      // committed words not yet read, in order
    logic [W-1:0] open_q[$];  // words of the packet being written
    int           lens[$];    // lengths of committed packets not fully read
    bit           rd_active;
    int           rem;
    bit           m_drop, m_err, m_acc;
    int           n_commit, n_read;

    // Samples taken at the falling edge.
    logic         s_ir, s_ov, s_ol, s_drop, s_err, s_aen;
    logic [W-1:0] s_od;
    logic [AW-1:0] s_aaddr, s_baddr;
    logic [CW-1:0] s_pc;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit iv, input logic [W-1:0] d, input bit il,
                         input bit ia, input bit ordy);
        reset     = rst;
        in_valid  = iv;
        in_data   = d;
        in_last   = il;
        in_abort  = ia;
        out_ready = ordy;
    endtask

    task automatic model_clear();
        cw.delete();
        open_q.delete();
        lens.delete();
        rd_active = 0;
        rem       = 0;
        m_drop    = 0;
        m_err     = 0;
    endtask

    // One clock: predict, sample and compare, then advance the model.
    task automatic step();
        bit e_ir, e_ov, e_ol, ovf, acc;
        int occ;
        occ  = cw.size() + open_q.size();
        e_ir = !reset && (occ < SIZE) && (lens.size() < PKT_DEPTH);
        e_ov = rd_active;
        e_ol = rd_active && (rem == 1);
        ovf  = (occ == SIZE) && (cw.size() == 0);
        acc  = in_valid && e_ir && !in_abort;
        @(negedge clock);
        s_ir = in_ready; s_ov = out_valid; s_ol = out_last; s_od = out_data;
        s_pc = pkt_count; s_drop = drop_pulse; s_err = err_overflow; s_aen = ram_a_enable;
        s_aaddr = ram_a_addr; s_baddr = ram_b_addr;
        check("m.in_ready", in_ready, e_ir);
        check("m.out_valid", out_valid, e_ov);
        check("m.out_last", out_last, e_ol);
        if (e_ov && out_valid && cw.size() > 0) check("m.out_data", out_data, cw[0]);
        check("m.pkt_count", pkt_count, lens.size());
        check("m.drop_pulse", drop_pulse, m_drop);
        check("m.err_overflow", err_overflow, m_err);
        check("m.ram_a_enable", ram_a_enable, acc);
        if (ram_a_enable && ram_b_enable) check("m.port_conflict", ram_a_addr == ram_b_addr, 0);
        if (out_valid && out_ready) n_read++;
        if (reset) begin
            model_clear();
        end else begin
            m_drop = in_abort;
            m_err  = ovf && !in_abort;
            if (rd_active) begin
                if (out_ready) begin
                    void'(cw.pop_front());
                    rem--;
                    if (rem == 0) begin
                        void'(lens.pop_front());
                        rd_active = 0;
                    end
                end
            end else if (lens.size() > 0) begin
                rd_active = 1;
                rem       = lens[0];
            end
            if (in_abort || ovf) begin
                open_q.delete();
            end else if (acc) begin
                open_q.push_back(in_data);
                if (in_last) begin
                    foreach (open_q[i]) cw.push_back(open_q[i]);
                    lens.push_back(open_q.size());
                    n_commit += open_q.size();
                    open_q.delete();
                end
            end
        end
        m_acc = acc;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        bit           rst, iv, il, ia, ordy;
        logic [W-1:0] d;
        bit           e_ir, e_ov, e_ol, e_drop, e_err, e_aen;
        logic [W-1:0] e_od;
        int           e_pc;
        int           e_baddr;  // -1: not checked
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit iv, logic [W-1:0] d, bit il, bit ia, bit ordy,
                                bit e_ir, bit e_ov, logic [W-1:0] e_od, bit e_ol, int e_pc,
                                bit e_drop, bit e_err, bit e_aen, int e_baddr);
        vec_t v;
        v.rst = rst; v.iv = iv; v.d = d; v.il = il; v.ia = ia; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol; v.e_pc = e_pc;
        v.e_drop = e_drop; v.e_err = e_err; v.e_aen = e_aen; v.e_baddr = e_baddr;
        return v;
    endfunction

    initial begin
        int pos, plen;
        logic [W-1:0] word;

        //            rst iv d      il ia or  ir ov od     ol pc dr er ae baddr
        // reset state, then a 3-word packet A,B,C
        vecs.push_back(mk(1, 0, 0,     0, 0, 1,  0, 0, 0,     0, 0, 0, 0, 0, -1));
        vecs.push_back(mk(0, 1, 'hA,   0, 0, 1,  1, 0, 0,     0, 0, 0, 0, 1, -1));
        vecs.push_back(mk(0, 1, 'hB,   0, 0, 1,  1, 0, 0,     0, 0, 0, 0, 1, -1));
        vecs.push_back(mk(0, 1, 'hC,   1, 0, 1,  1, 0, 0,     0, 0, 0, 0, 1, -1));
        vecs.push_back(mk(0, 0, 0,     0, 0, 1,  1, 0, 0,     0, 1, 0, 0, 0, -1));
        vecs.push_back(mk(0, 0, 0,     0, 0, 1,  1, 1, 'hA,   0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 1,  1, 1, 'hB,   0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,     0, 0, 1,  1, 1, 'hC,   1, 1, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0,     0, 0, 1,  1, 0, 0,     0, 0, 0, 0, 0, -1));
        // reset, two words, abort (with a word offered), then 1-word packet 0x55
        vecs.push_back(mk(1, 0, 0,     0, 0, 1,  0, 0, 0,     0, 0, 0, 0, 0, -1));
        vecs.push_back(mk(0, 1, 'h11,  0, 0, 1,  1, 0, 0,     0, 0, 0, 0, 1, -1));
        vecs.push_back(mk(0, 1, 'h22,  0, 0, 1,  1, 0, 0,     0, 0, 0, 0, 1, -1));
        vecs.push_back(mk(0, 1, 'h33,  0, 1, 1,  1, 0, 0,     0, 0, 0, 0, 0, -1));
        vecs.push_back(mk(0, 1, 'h55,  1, 0, 1,  1, 0, 0,     0, 0, 1, 0, 1, -1));
        vecs.push_back(mk(0, 0, 0,     0, 0, 1,  1, 0, 0,     0, 1, 0, 0, 0, -1));
        vecs.push_back(mk(0, 0, 0,     0, 0, 1,  1, 1, 'h55,  1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 1,  1, 0, 0,     0, 0, 0, 0, 0, -1));

        n_commit = 0;
        n_read   = 0;
        drive(1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        model_clear();

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.rst, v.iv, v.d, v.il, v.ia, v.ordy);
            step();
            check($sformatf("vec%0d.in_ready", i), s_ir, v.e_ir);
            check($sformatf("vec%0d.out_valid", i), s_ov, v.e_ov);
            check($sformatf("vec%0d.out_last", i), s_ol, v.e_ol);
            if (v.e_ov) check($sformatf("vec%0d.out_data", i), s_od, v.e_od);
            check($sformatf("vec%0d.pkt_count", i), s_pc, v.e_pc);
            check($sformatf("vec%0d.drop_pulse", i), s_drop, v.e_drop);
            check($sformatf("vec%0d.err_overflow", i), s_err, v.e_err);
            check($sformatf("vec%0d.ram_a_enable", i), s_aen, v.e_aen);
            if (v.e_baddr >= 0) check($sformatf("vec%0d.ram_b_addr", i), s_baddr, v.e_baddr);
        end

        // Open packet fills the RAM: auto-drop after the 4th word.
        drive(1, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 'h100 + i, 0, 0, 0);
            step();
            check("ovf.accept", s_aen, 1);
        end
        drive(0, 1, 'h104, 0, 0, 0); step();
        check("ovf.in_ready_low", s_ir, 0);
        step();
        check("ovf.err_pulse", s_err, 1);
        check("ovf.in_ready_back", s_ir, 1);
        check("ovf.pkt_count", s_pc, 0);
        drive(0, 0, 0, 0, 0, 0); step();
        check("ovf.err_single", s_err, 0);
        drive(0, 0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0, 0); step();
        check("ovf.abort_drop", s_drop, 1);

        // Length FIFO full with PKT_DEPTH=2.
        drive(1, 0, 0, 0, 0, 0); step();
        drive(0, 1, 'h201, 1, 0, 0); step();
        drive(0, 1, 'h202, 1, 0, 0); step();
        drive(0, 1, 'h203, 1, 0, 0); step();
        check("full.in_ready_low", s_ir, 0);
        drive(0, 1, 'h203, 1, 0, 1); step();
        check("full.still_low", s_ir, 0);
        check("full.first_out", s_od, 'h201);
        drive(0, 1, 'h203, 1, 0, 0); step();
        check("full.in_ready_freed", s_ir, 1);
        check("full.third_accepted", s_aen, 1);
        drive(0, 0, 0, 0, 0, 0); step();
        check("full.pkt_count", s_pc, 2);
        drive(0, 0, 0, 0, 0, 1);
        repeat (6) step();

        // Reset in the middle of streaming a packet.
        drive(1, 0, 0, 0, 0, 0); step();
        drive(0, 1, 'h301, 0, 0, 1); step();
        drive(0, 1, 'h302, 0, 0, 1); step();
        drive(0, 1, 'h303, 1, 0, 1); step();
        drive(0, 0, 0, 0, 0, 1); step();
        step();
        check("rst.streaming", s_ov, 1);
        drive(1, 0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 1); step();
        check("rst.out_valid", s_ov, 0);
        check("rst.pkt_count", s_pc, 0);
        drive(0, 1, 'h3AA, 1, 0, 1); step();
        check("rst.wr_addr", s_aaddr, 0);
        drive(0, 0, 0, 0, 0, 1); step();
        step();
        check("rst.rd_valid", s_ov, 1);
        check("rst.rd_addr", s_baddr, 0);
        check("rst.rd_data", s_od, 'h3AA);
        step();

        // Randomized traffic: full-size packets, then mixed lengths with aborts.
        drive(1, 0, 0, 0, 0, 0); step();
        n_commit = 0;
        n_read   = 0;
        pos      = 0;
        plen     = SIZE;
        word     = $urandom;
        for (int c = 0; c < 600; c++) begin
            bit ia;
            ia = (c >= 300) && ($urandom_range(0, 39) == 0);
            drive(0, $urandom_range(0, 9) < 8, word, pos == plen - 1, ia,
                  $urandom_range(0, 1));
            step();
            if (ia) begin
                pos = 0;
            end else if (m_acc) begin
                word = $urandom;
                if (in_last) begin
                    pos  = 0;
                    plen = (c >= 300) ? $urandom_range(1, SIZE) : SIZE;
                end else begin
                    pos++;
                end
            end
        end
        drive(0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 60 && (cw.size() > 0 || rd_active); c++) step();
        check("wrap.words_read", n_read, n_commit);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
